// File: rtl/mem_defs.sv
// Shared definitions for the memory-port arbiter: write codes and FSM states.
package mem_defs;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_WORD = 2'd1;
  localparam logic [1:0] MW_DMA  = 2'd2;
  localparam logic [1:0] MW_BYTE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/burst_ctr.sv
// Burst address/length tracker: loads a start command, advances one word per step.
module burst_ctr #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // Load takes priority; each step moves to the next word, address wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      cur_addr  <= cur_addr + ADDR_W'(4);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Cycle-stealing memory arbiter: CPU always wins, DMA bursts use idle CPU cycles.
//
// state | meaning
// IDLE  | no burst; waiting for dma_start
// BURST | words outstanding; granted whenever the CPU is idle
// DONE  | one-cycle completion pulse, then back to IDLE
module mem_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [1:0]        cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_gnt,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state, state_nxt;
  logic              cpu_act;
  logic              dir;
  logic              load, step, last;
  logic [ADDR_W-1:0] cur_addr;

  assign cpu_act   = cpu_read | (cpu_write != MW_NONE);
  assign cpu_rdata = mem_rdata;
  assign dma_busy  = (state != IDLE);
  assign dma_done  = (state == DONE);

  burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .load_addr (dma_addr),
    .load_len  (dma_len),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Burst direction latched with the start command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      dir <= 1'b0;
    else if (load) dir <= dma_we;
  end

  // Read capture: data registered on a granted read, strobe follows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt & ~dir;
      if (dma_gnt && !dir) dma_rdata <= mem_rdata;
    end
  end

  // Next state, grant and memory-port mux; the CPU owns the port whenever active.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    dma_gnt   = 1'b0;
    mem_read  = 1'b0;
    mem_write = MW_NONE;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            load      = 1'b1;
            state_nxt = BURST;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      BURST: begin
        if (!cpu_act) begin
          dma_gnt = 1'b1;
          step    = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (cpu_act) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_addr = cur_addr;
      if (dir) begin
        mem_write = MW_DMA;
        mem_wdata = dma_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Cycle-stealing arbiter that shares the single memory port between the CPU and a DMA burst engine. The CPU has absolute priority with zero added latency, because it has no stall input and samples read data at a fixed stage. The DMA side is granted only in cycles where the CPU drives neither a read nor a write. The arbiter sits between the CPU/BUS adapter and the memory, and sequences word bursts from a start/length command.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, burst length width in words

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_read  in  1  CPU memory read (Memread)
- cpu_write  in  2  CPU write code: 0 none, 1 word, 2 DMA, 3 byte
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU; combinational copy of mem_rdata
- dma_start  in  1  one-cycle burst command; honoured only in IDLE
- dma_we  in  1  burst direction: 1 write to memory, 0 read from memory
- dma_addr  in  ADDR_W  burst start address, word aligned
- dma_len  in  LEN_W  burst length in words
- dma_busy  out  1  high from accepted start until done
- dma_gnt  out  1  memory port owned by DMA this cycle; on writes it pops dma_wdata
- dma_wdata  in  DATA_W  write data, valid whenever dma_gnt is high
- dma_rvalid  out  1  registered read-data strobe
- dma_rdata  out  DATA_W  registered read data
- dma_done  out  1  one-cycle burst-complete pulse
- mem_read  out  1  memory read
- mem_write  out  2  memory write code
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational (valid in the same cycle as mem_read)

## Operation
- Port ownership:
  - cpu_act = cpu_read | (cpu_write != 0).
  - When cpu_act is high, all mem_* outputs equal the cpu_* inputs, combinationally.
- DMA grant:
  - dma_gnt = (state == BURST) & ~cpu_act.
  - In a granted cycle, mem_addr = cur_addr.
  - Write bursts: mem_write = 2 (DMA code), mem_wdata = dma_wdata, mem_read = 0.
  - Read bursts: mem_read = 1, mem_write = 0.
- Idle port: when neither side owns the port, all mem_* outputs are 0.
- State machine:
  - IDLE: on dma_start with dma_len != 0, latch dir, cur_addr = dma_addr and remaining = dma_len, then go to BURST. On dma_start with dma_len == 0, go to DONE without issuing any access.
  - BURST: on each granted cycle, cur_addr += 4 (modulo 2^ADDR_W, wraps silently) and remaining -= 1. Go to DONE on the grant where remaining == 1.
  - DONE: dma_done = 1 for this one cycle, then return to IDLE.
- dma_busy is high in BURST and DONE.
- dma_start is ignored unless the state is IDLE.
- Read capture: on a granted read cycle, dma_rdata <= mem_rdata and dma_rvalid pulses the next cycle. Otherwise dma_rvalid = 0 and dma_rdata holds its value.
- Reset (rst low, any time, including mid-burst):
  - state = IDLE; cur_addr, remaining, dma_rdata = 0; dma_rvalid, dma_done = 0.
  - The burst is abandoned with no done pulse.
  - Combinational CPU pass-through stays functional during reset; no DMA grant is possible while in IDLE.

## Timing
- CPU path latency: 0 cycles, purely combinational.
- dma_start accepted at cycle T; the earliest grant is at T+1.
- Read data: dma_rvalid is asserted at cycle G+1 for a grant at cycle G.
- dma_done is asserted the cycle after the last grant. For read bursts this is the same cycle as the last dma_rvalid.
- dma_len == 0: dma_done is asserted at T+1.
- The CPU may assert in any cycle, including the cycle immediately after a DMA grant. The DMA simply waits; no DMA access is ever split or retried.
- Throughput: at most one DMA word per cycle in which the CPU is idle.

## Structure
- Shared package mem_defs:
  - Write-code constants MW_NONE = 0, MW_WORD = 1, MW_DMA = 2, MW_BYTE = 3.
  - Arbiter state encoding IDLE / BURST / DONE.
- Sub-module burst_ctr holds cur_addr and remaining. It takes load and step inputs and produces a last flag, with the same reset behaviour as the arbiter.

## Test plan
- CPU only: cpu_read = 1, cpu_addr = 0x40, mem_rdata = 0xDEADBEEF -> in the same cycle mem_addr = 0x40, cpu_rdata = 0xDEADBEEF; dma_gnt = 0.
- Idle-CPU read burst: start addr = 0x100, len = 4, CPU idle -> grants at T+1..T+4 with mem_addr 0x100, 0x104, 0x108, 0x10C; dma_rvalid at T+2..T+5; dma_done at T+5.
- Contention write burst: len = 3, cpu_write = 1 at T+1 and T+3 -> grants at T+2, T+4, T+5; mem_write = 2 on those cycles and 1 on the CPU cycles; dma_done at T+6.
- Edge cases: len = 0 -> dma_done at T+1 with no grant. A second start while busy is ignored. Start addr = 0xFFFFFFFC, len = 2 -> addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: rst low after 2 of 5 words -> dma_busy = 0, no dma_done. A new start after reset runs normally from its own dma_addr.
